// File: rtl/sonata_pkg.sv
// Shared SPI definitions for the Sonata peripherals: target FSM states and
// target-side defaults.
package sonata_pkg;

    typedef enum logic {
        SPI_TGT_IDLE     = 1'b0,
        SPI_TGT_SELECTED = 1'b1
    } spi_tgt_state_e;

    localparam int unsigned SPI_TGT_SYNC_STAGES    = 2;
    localparam logic [7:0]  SPI_TGT_UNDERFLOW_BYTE = 8'hFF;

endpackage

// File: rtl/prim_flop_2sync.sv
// Multi-stage flop synchroniser for asynchronous single-bit or bundled inputs.
module prim_flop_2sync #(
    parameter int unsigned     Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0,
    parameter int unsigned     NumStages  = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [NumStages-1:0][Width-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= {NumStages{ResetValue}};
        end else begin
            stage_q <= {stage_q[NumStages-2:0], d_i};
        end
    end

    assign q_o = stage_q[NumStages-1];

endmodule

// File: rtl/spi_target.sv
// Mode-0 SPI target oversampled in the system clock domain, with a byte-wide
// valid/ready receive port and a one-byte transmit holding register.
module spi_target
    import sonata_pkg::*;
#(
    parameter int unsigned SyncStages    = SPI_TGT_SYNC_STAGES,
    parameter logic [7:0]  UnderflowByte = SPI_TGT_UNDERFLOW_BYTE
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       spi_sck_i,
    input  logic       spi_cs_ni,
    input  logic       spi_copi_i,
    output logic       spi_cipo_o,
    output logic       spi_cipo_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       rx_overflow_o,
    output logic       tx_underflow_o,
    output logic       active_o
);

    // All three pins share one synchroniser so they stay cycle-aligned.
    logic [2:0] pins_sync;
    logic       sck_sync, cs_n_sync, copi_sync;

    prim_flop_2sync #(
        .Width      (3),
        .ResetValue (3'b010),
        .NumStages  (SyncStages)
    ) u_pin_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({spi_sck_i, spi_cs_ni, spi_copi_i}),
        .q_o    (pins_sync)
    );

    assign sck_sync  = pins_sync[2];
    assign cs_n_sync = pins_sync[1];
    assign copi_sync = pins_sync[0];

    spi_tgt_state_e state_q, state_d;
    logic       sck_prev_q;
    logic       cs_n_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       full_q, full_d;
    logic       cipo_q, cipo_d;
    logic       cipo_en_q, cipo_en_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_overflow_q, rx_overflow_d;
    logic       tx_underflow_q, tx_underflow_d;

    logic       sck_rise, sck_fall, cs_fall, cs_rise;
    logic       rx_complete, tx_load;
    logic [7:0] rx_byte;

    assign sck_rise = sck_sync & ~sck_prev_q;
    assign sck_fall = ~sck_sync & sck_prev_q;
    assign cs_fall  = ~cs_n_sync & cs_n_prev_q;
    assign cs_rise  = cs_n_sync & ~cs_n_prev_q;
    assign rx_byte  = {rx_shift_q, copi_sync};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SPI_TGT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        hold_d         = hold_q;
        full_d         = full_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = rx_valid_q;
        rx_overflow_d  = 1'b0;
        tx_underflow_d = 1'b0;
        rx_complete    = 1'b0;
        tx_load        = 1'b0;

        case (state_q)
            SPI_TGT_IDLE: begin
                if (cs_fall) begin
                    state_d    = SPI_TGT_SELECTED;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 7'd0;
                    tx_load    = 1'b1;
                end
            end
            SPI_TGT_SELECTED: begin
                // Deselect wins over a coincident SCK edge; partial bytes are dropped.
                if (cs_rise) begin
                    state_d    = SPI_TGT_IDLE;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 7'd0;
                end else if (sck_rise) begin
                    rx_shift_d  = rx_byte[6:0];
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    rx_complete = (bit_cnt_q == 3'd7);
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = SPI_TGT_IDLE;
            end
        endcase

        if (tx_load) begin
            if (full_q) begin
                tx_shift_d = hold_q;
                full_d     = 1'b0;
            end else begin
                tx_shift_d     = UnderflowByte;
                tx_underflow_d = 1'b1;
            end
        end

        // Ready is taken from the registered full flag, so a byte consumed this
        // cycle can only be refilled from the next cycle on.
        if (tx_valid_i && !full_q) begin
            hold_d = tx_data_i;
            full_d = 1'b1;
        end

        if (rx_complete) begin
            if (!rx_valid_q || rx_ready_i) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
            end else begin
                rx_overflow_d = 1'b1;
            end
        end else if (rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        cipo_en_d = (state_d == SPI_TGT_SELECTED);
        cipo_d    = cipo_en_d ? tx_shift_d[7] : 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_prev_q     <= 1'b0;
            cs_n_prev_q    <= 1'b1;
            bit_cnt_q      <= 3'd0;
            rx_shift_q     <= 7'd0;
            tx_shift_q     <= 8'd0;
            hold_q         <= 8'd0;
            full_q         <= 1'b0;
            cipo_q         <= 1'b0;
            cipo_en_q      <= 1'b0;
            rx_data_q      <= 8'd0;
            rx_valid_q     <= 1'b0;
            rx_overflow_q  <= 1'b0;
            tx_underflow_q <= 1'b0;
        end else begin
            sck_prev_q     <= sck_sync;
            cs_n_prev_q    <= cs_n_sync;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            hold_q         <= hold_d;
            full_q         <= full_d;
            cipo_q         <= cipo_d;
            cipo_en_q      <= cipo_en_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_overflow_q  <= rx_overflow_d;
            tx_underflow_q <= tx_underflow_d;
        end
    end

    assign spi_cipo_o     = cipo_q;
    assign spi_cipo_en_o  = cipo_en_q;
    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign tx_ready_o     = ~full_q;
    assign rx_overflow_o  = rx_overflow_q;
    assign tx_underflow_o = tx_underflow_q;
    assign active_o       = (state_q == SPI_TGT_SELECTED);

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: host driven at the fclk/8 SCK limit.
module tb_spi_target;

    logic       clk;
    logic       rst_ni;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_copi;
    logic       spi_cipo_o;
    logic       spi_cipo_en_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       rx_overflow_o;
    logic       tx_underflow_o;
    logic       active_o;

    spi_target dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .spi_sck_i      (spi_sck),
        .spi_cs_ni      (spi_cs_n),
        .spi_copi_i     (spi_copi),
        .spi_cipo_o     (spi_cipo_o),
        .spi_cipo_en_o  (spi_cipo_en_o),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (rx_ready_i),
        .tx_data_i      (tx_data_i),
        .tx_valid_i     (tx_valid_i),
        .tx_ready_o     (tx_ready_o),
        .rx_overflow_o  (rx_overflow_o),
        .tx_underflow_o (tx_underflow_o),
        .active_o       (active_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int under_cnt = 0;
    int over_cnt = 0;
    bit mon_en = 1'b0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (tx_underflow_o === 1'b1) under_cnt++;
        if (rx_overflow_o === 1'b1) over_cnt++;
        if (mon_en && rx_valid_o === 1'b1 && rx_ready_i === 1'b1) rx_q.push_back(rx_data_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SCK period: COPI set with SCK low, CIPO sampled just before the rise.
    task automatic spi_bit(input bit first, input logic b, output logic cipo_b);
        if (!first) spi_sck = 1'b0;
        spi_copi = b;
        repeat (4) @(negedge clk);
        cipo_b  = spi_cipo_o;
        spi_sck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_byte(input bit first, input logic [7:0] b, output logic [7:0] c);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(first && (i == 7), b[i], t);
            c[i] = t;
        end
    endtask

    task automatic cs_end();
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        int n = 0;
        while (tx_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", tx_ready_o, 1);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        logic       t;
        int         u0, o0;
        logic [7:0] tx_arr[64];
        logic [7:0] rx_arr[64];

        rst_ni     = 1'b0;
        spi_sck    = 1'b0;
        spi_cs_n   = 1'b1;
        spi_copi   = 1'b0;
        rx_ready_i = 1'b0;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cipo", spi_cipo_o, 0);
        check("rst_cipo_en", spi_cipo_en_o, 0);
        check("rst_rx_data", rx_data_o, 8'h00);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_tx_ready", tx_ready_o, 1);
        check("rst_overflow", rx_overflow_o, 0);
        check("rst_underflow", tx_underflow_o, 0);
        check("rst_active", active_o, 0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // Empty holding register: underflow byte on CIPO, 0xA5 received.
        spi_cs_n = 1'b0;
        spi_byte(1'b1, 8'hA5, c);
        check("t1_cipo_byte", c, 8'hFF);
        check("t1_cipo_en", spi_cipo_en_o, 1);
        check("t1_active", active_o, 1);
        check("t1_rx_valid", rx_valid_o, 1);
        check("t1_rx_data", rx_data_o, 8'hA5);
        cs_end();
        check("t1_cipo_en_off", spi_cipo_en_o, 0);
        check("t1_active_off", active_o, 0);
        check("t1_underflows", under_cnt, 1);

        // Preloaded 0x3C, 0x81 refilled mid-transfer.
        rx_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rx_q.delete();
        mon_en = 1'b1;
        u0 = under_cnt;
        load_tx(8'h3C);
        check("t2_tx_full", tx_ready_o, 0);
        spi_cs_n = 1'b0;
        spi_byte(1'b1, 8'h12, c);
        check("t2_cipo_b0", c, 8'h3C);
        check("t2_tx_empty", tx_ready_o, 1);
        load_tx(8'h81);
        spi_byte(1'b0, 8'h34, c);
        check("t2_cipo_b1", c, 8'h81);
        cs_end();
        mon_en = 1'b0;
        check("t2_rx_count", rx_q.size(), 2);
        check("t2_rx_b0", rx_q[0], 8'h12);
        check("t2_rx_b1", rx_q[1], 8'h34);
        check("t2_no_underflow", under_cnt, u0);

        // Overflow when unconsumed, replace when ready coincides with completion.
        rx_ready_i = 1'b0;
        o0 = over_cnt;
        spi_cs_n = 1'b0;
        spi_byte(1'b1, 8'h11, c);
        check("t3_rx_b0", rx_data_o, 8'h11);
        check("t3_rx_valid", rx_valid_o, 1);
        spi_byte(1'b0, 8'h22, c);
        check("t3_rx_kept", rx_data_o, 8'h11);
        check("t3_overflow", over_cnt, o0 + 1);
        for (int i = 7; i >= 1; i--) spi_bit(1'b0, (i == 5 || i == 4 || i == 1), t);
        spi_sck  = 1'b0;
        spi_copi = 1'b1;
        repeat (4) @(negedge clk);
        spi_sck = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_rx_replaced", rx_data_o, 8'h33);
        check("t3_rx_valid_kept", rx_valid_o, 1);
        check("t3_no_overflow", over_cnt, o0 + 1);
        cs_end();

        // Deselect after 5 bits, then a clean 0xF0.
        rx_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready_i = 1'b0;
        check("t4_rx_cleared", rx_valid_o, 0);
        spi_cs_n = 1'b0;
        for (int i = 0; i < 5; i++) spi_bit(i == 0, 1'b1, t);
        cs_end();
        check("t4_cipo_en_gap", spi_cipo_en_o, 0);
        check("t4_no_partial", rx_valid_o, 0);
        spi_cs_n = 1'b0;
        spi_byte(1'b1, 8'hF0, c);
        check("t4_rx_valid", rx_valid_o, 1);
        check("t4_rx_data", rx_data_o, 8'hF0);
        cs_end();
        check("t4_cipo_en_end", spi_cipo_en_o, 0);

        // Reset mid-byte with the holding register full.
        spi_cs_n = 1'b0;
        for (int i = 0; i < 3; i++) spi_bit(i == 0, 1'b0, t);
        load_tx(8'h77);
        check("t5_tx_full", tx_ready_o, 0);
        rst_ni = 1'b0;
        #1;
        check("t5_cipo", spi_cipo_o, 0);
        check("t5_cipo_en", spi_cipo_en_o, 0);
        check("t5_rx_valid", rx_valid_o, 0);
        check("t5_rx_data", rx_data_o, 8'h00);
        check("t5_tx_ready", tx_ready_o, 1);
        check("t5_active", active_o, 0);
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_tx_ready_rel", tx_ready_o, 1);
        u0 = under_cnt;
        spi_cs_n = 1'b0;
        spi_byte(1'b1, 8'h5A, c);
        check("t5_cipo_underflow", c, 8'hFF);
        check("t5_underflow", under_cnt, u0 + 1);
        check("t5_rx_data_after", rx_data_o, 8'h5A);
        cs_end();

        // 64 random bytes each way at the SCK rate limit.
        rx_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rx_q.delete();
        mon_en = 1'b1;
        u0 = under_cnt;
        o0 = over_cnt;
        for (int i = 0; i < 64; i++) begin
            tx_arr[i] = 8'($urandom_range(0, 255));
            rx_arr[i] = 8'($urandom_range(0, 255));
        end
        load_tx(tx_arr[0]);
        spi_cs_n = 1'b0;
        for (int i = 0; i < 64; i++) begin
            spi_byte(i == 0, rx_arr[i], c);
            if (i < 63) load_tx(tx_arr[i + 1]);
            check($sformatf("t6_cipo_%0d", i), c, tx_arr[i]);
        end
        cs_end();
        mon_en = 1'b0;
        check("t6_rx_count", rx_q.size(), 64);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("t6_rx_%0d", i), rx_q[i], rx_arr[i]);
        end
        check("t6_no_underflow", under_cnt, u0);
        check("t6_no_overflow", over_cnt, o0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
